sha_multi_state: RTL and testbench

- Parametrised multi-lane chaining-state accumulator for the Versat SHA datapath.
- Holds LANES words of hash state.
- After a `run` and a programmable delay, it consumes one `in0` word per cycle for LANES consecutive cycles.
  - add mode: each word is added (mod 2^DATA_W) into its lane.
  - load mode: each word overwrites its lane.
- Every lane is readable and writable through the unit's memory-mapped data/control interface; the full state is exported as a flat bus.

---
 rtl/sha_multi_state_if.sv | 23 ++
 rtl/sha_multi_state.sv | 126 ++++++++++++
 tb/tb_sha_multi_state.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_multi_state_if.sv
// Memory-mapped access port of the SHA chaining-state accumulator.
// Single-cycle valid/ready handshake with byte strobes.
interface sha_multi_state_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
);
  logic                  valid;
  logic [IDX_W-1:0]      addr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     wdata;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output valid, addr, wstrb, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wstrb, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/sha_multi_state.sv
// Multi-lane chaining-state accumulator for the Versat SHA datapath.
// Streams in0 into LANES state words (add or load) after a delay.
module sha_multi_state #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int IDX_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  output logic                    done,
  input  logic                    mode,
  input  logic [31:0]             delay0,
  input  logic [DATA_W-1:0]       in0,
  output logic [DATA_W-1:0]       out0,
  output logic [LANES*DATA_W-1:0] currentValue,
  sha_multi_state_if.slave        mm
);

  localparam int NB = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_ACC   = 2'd2;

  localparam logic [IDX_W:0]   LANES_C = (IDX_W+1)'(LANES);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(LANES - 1);

  logic [DATA_W-1:0] lane_q [LANES];
  logic [DATA_W-1:0] lane_d [LANES];

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              ready_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              acc_en;
  logic              hit;

  assign hit = {1'b0, mm.addr} < LANES_C;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    acc_en  = 1'b0;
    // A run pulse restarts from any state and wins over the cycle's work
    if (run) begin
      mode_d = mode;
      idx_d  = '0;
      if (delay0 == 32'd0) begin
        state_d = S_ACC;
      end else begin
        state_d = S_DELAY;
        cnt_d   = delay0 - 32'd1;
      end
    end else begin
      unique case (state_q)
        S_DELAY: begin
          if (cnt_q == 32'd0) state_d = S_ACC;
          else                cnt_d   = cnt_q - 32'd1;
        end
        S_ACC: begin
          acc_en = 1'b1;
          if (idx_q == LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_d = lane_q;
    if (mm.valid && hit) begin
      for (int b = 0; b < NB; b++) begin
        if (mm.wstrb[b]) lane_d[mm.addr][8*b +: 8] = mm.wdata[8*b +: 8];
      end
    end
    // Stream update is applied last so it beats a same-lane bus write
    if (acc_en) begin
      lane_d[idx_q] = mode_q ? in0 : lane_q[idx_q] + in0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (mm.valid && hit && (mm.wstrb == '0)) rdata_d = lane_q[mm.addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ready_q <= mm.valid;
      rdata_q <= rdata_d;
      for (int k = 0; k < LANES; k++) lane_q[k] <= lane_d[k];
    end
  end

  assign done     = (state_q == S_IDLE);
  assign out0     = lane_q[idx_q];
  assign mm.ready = ready_q;
  assign mm.rdata = rdata_q;

  for (genvar k = 0; k < LANES; k++) begin : g_cv
    assign currentValue[k*DATA_W +: DATA_W] = lane_q[k];
  end

endmodule

// File: tb/tb_sha_multi_state.sv
// Self-checking bench for sha_multi_state.
// Scenario tasks with a queue scoreboard for bus read data.
module tb_sha_multi_state;

  localparam int DW = 32;
  localparam int NL = 8;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           run;
  logic           done;
  logic           mode;
  logic [31:0]    delay0;
  logic [DW-1:0]  in0;
  logic [DW-1:0]  out0;
  logic [NL*DW-1:0] currentValue;

  sha_multi_state_if #(.DATA_W(DW), .IDX_W(IW)) mm ();

  sha_multi_state #(.DATA_W(DW), .LANES(NL)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .done         (done),
    .mode         (mode),
    .delay0       (delay0),
    .in0          (in0),
    .out0         (out0),
    .currentValue (currentValue),
    .mm           (mm)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] m [NL];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NL*DW-1:0] model_cv();
    logic [NL*DW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*DW +: DW] = m[k];
    return v;
  endfunction

  task automatic mm_req(input int a, input logic [3:0] s,
                        input logic [DW-1:0] d);
    mm.valid = 1'b1;
    mm.addr  = IW'(a);
    mm.wstrb = s;
    mm.wdata = d;
    tick();
    mm.valid = 1'b0;
    mm.wstrb = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < NL; k++) m[k] = '0;
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_done got %b want 1", done);
    end
    n_chk++;
    if (mm.ready !== 1'b0 || mm.rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got ready=%b rdata=%h want 0/0",
               mm.ready, mm.rdata);
    end
    n_chk++;
    if (currentValue !== model_cv()) begin
      n_fail++;
      $display("FAIL reset_lanes got %h want 0", currentValue);
    end
    for (int k = 0; k < NL; k++) begin
      exp_q.push_back(m[k]);
      mm_req(k, 4'h0, '0);
      e = exp_q.pop_front();
      n_chk++;
      if (mm.ready !== 1'b1 || mm.rdata !== e) begin
        n_fail++;
        $display("FAIL reset_read%0d got ready=%b rdata=%h want 1/%h",
                 k, mm.ready, mm.rdata, e);
      end
    end
    tick();
    n_chk++;
    if (mm.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_drop got %b want 0", mm.ready);
    end
  endtask

  task automatic test_load();
    logic [DW-1:0] iv [NL];
    iv = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
           32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    run = 1'b1; mode = 1'b1; delay0 = 0;
    tick();
    run = 1'b0;
    for (int k = 0; k < NL; k++) begin
      in0 = iv[k];
      n_chk++;
      if (done !== 1'b0 || out0 !== m[k]) begin
        n_fail++;
        $display("FAIL load_cyc%0d got done=%b out0=%h want 0/%h",
                 k, done, out0, m[k]);
      end
      tick();
      m[k] = iv[k];
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done got %b want 1", done);
    end
    n_chk++;
    if (currentValue !== model_cv()) begin
      n_fail++;
      $display("FAIL load_lanes got %h want %h", currentValue, model_cv());
    end
  endtask

  task automatic test_add_wrap();
    for (int k = 0; k < NL; k++) begin
      mm_req(k, 4'hF, 32'hFFFF_FFFF);
      m[k] = 32'hFFFF_FFFF;
    end
    run = 1'b1; mode = 1'b0; delay0 = 3; in0 = 32'd2;
    tick();
    run = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_chk++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL add_delay%0d got done=%b want 0", c, done);
      end
      tick();
    end
    n_chk++;
    if (out0 !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL add_out0 got %h want ffffffff", out0);
    end
    for (int k = 0; k < NL; k++) begin
      tick();
      m[k] = m[k] + 32'd2;
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL add_done got %b want 1", done);
    end
    n_chk++;
    if (currentValue !== model_cv() || m[0] !== 32'd1) begin
      n_fail++;
      $display("FAIL add_lanes got %h want %h", currentValue, model_cv());
    end
  endtask

  task automatic test_strobe();
    mm_req(3, 4'hF, 32'h11223344);
    n_chk++;
    if (mm.ready !== 1'b1 || mm.rdata !== '0) begin
      n_fail++;
      $display("FAIL wr_ack got ready=%b rdata=%h want 1/0",
               mm.ready, mm.rdata);
    end
    mm_req(3, 4'b0101, 32'hAABBCCDD);
    m[3] = 32'h11BB33DD;
    exp_q.push_back(m[3]);
    mm_req(3, 4'h0, '0);
    e = exp_q.pop_front();
    n_chk++;
    if (mm.rdata !== e) begin
      n_fail++;
      $display("FAIL strobe_read got %h want %h", mm.rdata, e);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] v;
    run = 1'b1; mode = 1'b0; delay0 = 0;
    tick();
    run = 1'b0;
    for (int k = 0; k < NL; k++) begin
      v = (k == 5) ? 32'd0 : 32'h100 + k;
      in0 = v;
      if (k == 2 || k == 3) begin
        mm.valid = 1'b1;
        mm.addr  = IW'(k == 2 ? 2 : 5);
        mm.wstrb = 4'hF;
        mm.wdata = 32'h0000DEAD;
      end
      tick();
      mm.valid = 1'b0;
      mm.wstrb = '0;
      if (k == 3) m[5] = 32'h0000DEAD;
      m[k] = m[k] + v;
      if (k == 2 || k == 3) begin
        n_chk++;
        if (mm.ready !== 1'b1) begin
          n_fail++;
          $display("FAIL coll_ack%0d got %b want 1", k, mm.ready);
        end
      end
    end
    n_chk++;
    if (currentValue[2*DW +: DW] !== m[2]) begin
      n_fail++;
      $display("FAIL coll_lane2 got %h want %h",
               currentValue[2*DW +: DW], m[2]);
    end
    n_chk++;
    if (currentValue[5*DW +: DW] !== 32'h0000DEAD) begin
      n_fail++;
      $display("FAIL coll_lane5 got %h want 0000dead",
               currentValue[5*DW +: DW]);
    end
  endtask

  task automatic test_restart();
    run = 1'b1; mode = 1'b0; delay0 = 0;
    tick();
    run = 1'b0;
    in0 = 32'h1000;
    tick();
    m[0] = m[0] + 32'h1000;
    run = 1'b1;
    in0 = 32'd0;
    tick();
    run = 1'b0;
    n_chk++;
    if (out0 !== m[0] || done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_idx got out0=%h done=%b want %h/0",
               out0, done, m[0]);
    end
    for (int k = 0; k < NL; k++) begin
      in0 = 32'h10 * (k + 1);
      tick();
      m[k] = m[k] + 32'h10 * (k + 1);
    end
    n_chk++;
    if (done !== 1'b1 || currentValue !== model_cv()) begin
      n_fail++;
      $display("FAIL restart_lanes got done=%b cv=%h want 1/%h",
               done, currentValue, model_cv());
    end
  endtask

  task automatic test_reset_mid();
    run = 1'b1; mode = 1'b1; delay0 = 0;
    tick();
    run = 1'b0;
    in0 = 32'hCAFE0001;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NL; k++) m[k] = '0;
    n_chk++;
    if (done !== 1'b1 || currentValue !== model_cv()) begin
      n_fail++;
      $display("FAIL rst_mid got done=%b cv=%h want 1/0",
               done, currentValue);
    end
    tick();
    tick();
    n_chk++;
    if (currentValue !== model_cv()) begin
      n_fail++;
      $display("FAIL rst_stale got %h want 0", currentValue);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NL; k++) begin
      mm.valid = 1'b1;
      mm.addr  = IW'(k);
      mm.wstrb = 4'hF;
      mm.wdata = 32'hC0DE0000 + k;
      exp_q.push_back('0);
      tick();
      m[k] = 32'hC0DE0000 + k;
      e = exp_q.pop_front();
      n_chk++;
      if (mm.ready !== 1'b1 || mm.rdata !== e) begin
        n_fail++;
        $display("FAIL b2b_wr%0d got ready=%b rdata=%h want 1/%h",
                 k, mm.ready, mm.rdata, e);
      end
    end
    for (int k = NL - 1; k >= 0; k--) begin
      mm.valid = 1'b1;
      mm.addr  = IW'(k);
      mm.wstrb = 4'h0;
      exp_q.push_back(m[k]);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (mm.ready !== 1'b1 || mm.rdata !== e) begin
        n_fail++;
        $display("FAIL b2b_rd%0d got ready=%b rdata=%h want 1/%h",
                 k, mm.ready, mm.rdata, e);
      end
    end
    mm.valid = 1'b0;
    tick();
    n_chk++;
    if (mm.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle got %b want 0", mm.ready);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mode = 1'b0; delay0 = '0; in0 = '0;
    mm.valid = 1'b0; mm.addr = '0; mm.wstrb = '0; mm.wdata = '0;
    test_reset();
    test_load();
    test_add_wrap();
    test_strobe();
    test_collision();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
